// File: rtl/pwm_grados_decoder_if.sv
`default_nettype none
// ============================================================================
//  Module      : pwm_grados_decoder_if
//  Description : Signal bundle between a servo PWM source / angle consumer
//                (master) and the PWM-to-degrees decoder (slave).
//  Revision    : 1.0  initial release
// ============================================================================
interface pwm_grados_decoder_if;
    logic       pwm_in;
    logic [7:0] grados;
    logic       valid;
    logic       signal_lost;
    logic [3:0] unidades;
    logic [3:0] decenas;
    logic [1:0] centenas;
    logic [6:0] wire_unidades;
    logic [6:0] wire_decenas;
    logic [6:0] wire_centenas;

    modport master (
        output pwm_in,
        input  grados, valid, signal_lost, unidades, decenas, centenas,
        input  wire_unidades, wire_decenas, wire_centenas
    );

    modport slave (
        input  pwm_in,
        output grados, valid, signal_lost, unidades, decenas, centenas,
        output wire_unidades, wire_decenas, wire_centenas
    );
endinterface
`default_nettype wire

// File: rtl/pwm_grados_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : segmentos_7 / pwm_grados_decoder
//  Description : Measures the high time of a servo PWM pulse, converts it to
//                degrees (0..MAX_DEG), splits it into BCD digits and drives
//                three seven-segment displays. Flags loss of PWM activity.
//  Revision    : 1.0  initial release
// ============================================================================

// BCD digit to active-low seven-segment code, bit order {g,f,e,d,c,b,a}.
module segmentos_7 (
    input  wire logic [3:0] i_bcd,
    output logic      [6:0] o_seg
);
    // Pure lookup; codes above 9 blank the display.
    always_comb begin
        o_seg = 7'b1111111;
        case (i_bcd)
            4'd0: o_seg = 7'b1000000;
            4'd1: o_seg = 7'b1111001;
            4'd2: o_seg = 7'b0100100;
            4'd3: o_seg = 7'b0110000;
            4'd4: o_seg = 7'b0011001;
            4'd5: o_seg = 7'b0010010;
            4'd6: o_seg = 7'b0000010;
            4'd7: o_seg = 7'b1111000;
            4'd8: o_seg = 7'b0000000;
            4'd9: o_seg = 7'b0010000;
            default: o_seg = 7'b1111111;
        endcase
    end
endmodule

module pwm_grados_decoder #(
    parameter int unsigned MIN_PULSE = 50000,
    parameter int unsigned STEP      = 277,
    parameter int unsigned MAX_DEG   = 180,
    parameter int unsigned GLITCH    = 1000,
    parameter int unsigned TIMEOUT   = 2000000
) (
    input  wire logic            clk,
    input  wire logic            rst,
    pwm_grados_decoder_if.slave  bus
);
    localparam logic [7:0] c_MAX_DEG = MAX_DEG[7:0];

    typedef enum logic [0:0] {MS_WAIT_RISE = 1'b0, MS_HIGH = 1'b1} meas_t;
    typedef enum logic [1:0] {BS_IDLE = 2'd0, BS_SHIFT = 2'd1, BS_DONE = 2'd2} bcd_t;

    // ---------------- input synchronizer + edge detect -----------------------
    logic r_s1, r_s2, r_s3;
    logic w_rise, w_fall;

    // Flops reset high so a pulse already high at reset release never
    // looks like a rising edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_s1 <= 1'b1;
            r_s2 <= 1'b1;
            r_s3 <= 1'b1;
        end else begin
            r_s1 <= bus.pwm_in;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    assign w_rise = r_s2 & ~r_s3;
    assign w_fall = ~r_s2 & r_s3;

    // ---------------- measurement FSM ----------------------------------------
    meas_t       r_ms, w_ms_nxt;
    logic [31:0] r_hi_cnt, w_hi_nxt;
    logic [31:0] r_step_cnt, w_step_nxt;
    logic [7:0]  r_deg_acc, w_deg_nxt;
    logic        r_accept, w_accept;
    logic [7:0]  r_accept_deg;

    // State and counter registers of the pulse measurement.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ms         <= MS_WAIT_RISE;
            r_hi_cnt     <= '0;
            r_step_cnt   <= '0;
            r_deg_acc    <= '0;
            r_accept     <= 1'b0;
            r_accept_deg <= '0;
        end else begin
            r_ms         <= w_ms_nxt;
            r_hi_cnt     <= w_hi_nxt;
            r_step_cnt   <= w_step_nxt;
            r_deg_acc    <= w_deg_nxt;
            r_accept     <= w_accept;
            r_accept_deg <= w_deg_nxt;
        end
    end

    // In HIGH every cycle corresponds to one high sample (the delayed sample
    // r_s3 is high throughout, including the falling-edge cycle), so the
    // incremented count on the fall cycle is exactly the pulse width W.
    always_comb begin
        w_ms_nxt   = r_ms;
        w_hi_nxt   = r_hi_cnt;
        w_step_nxt = r_step_cnt;
        w_deg_nxt  = r_deg_acc;
        w_accept   = 1'b0;
        case (r_ms)
            MS_WAIT_RISE: begin
                if (w_rise) begin
                    w_hi_nxt   = '0;
                    w_step_nxt = '0;
                    w_deg_nxt  = '0;
                    w_ms_nxt   = MS_HIGH;
                end
            end
            MS_HIGH: begin
                w_hi_nxt = r_hi_cnt + 32'd1;
                if (r_hi_cnt >= MIN_PULSE) begin
                    if (r_step_cnt == STEP - 32'd1) begin
                        w_step_nxt = '0;
                        if (r_deg_acc < c_MAX_DEG)
                            w_deg_nxt = r_deg_acc + 8'd1;
                    end else begin
                        w_step_nxt = r_step_cnt + 32'd1;
                    end
                end
                if (w_fall) begin
                    w_ms_nxt = MS_WAIT_RISE;
                    w_accept = (w_hi_nxt >= GLITCH);
                end else if (w_hi_nxt >= TIMEOUT) begin
                    w_ms_nxt = MS_WAIT_RISE;
                end
            end
            default: w_ms_nxt = MS_WAIT_RISE;
        endcase
    end

    // ---------------- BCD converter FSM --------------------------------------
    bcd_t        r_bs, w_bs_nxt;
    logic [19:0] r_scratch, w_scr_nxt, w_adj, w_shifted;
    logic [2:0]  r_shift_cnt, w_cnt_nxt;
    logic [7:0]  r_deg_hold, w_hold_nxt;
    logic [7:0]  r_grados, w_grados_nxt;
    logic [1:0]  r_cent, w_cent_nxt;
    logic [3:0]  r_dec, w_dec_nxt;
    logic [3:0]  r_uni, w_uni_nxt;
    logic        r_valid, w_valid_nxt;

    // Double-dabble step: add 3 to each BCD nibble >= 5, then shift left.
    always_comb begin
        w_adj = r_scratch;
        if (r_scratch[11:8]  >= 4'd5) w_adj[11:8]  = r_scratch[11:8]  + 4'd3;
        if (r_scratch[15:12] >= 4'd5) w_adj[15:12] = r_scratch[15:12] + 4'd3;
        if (r_scratch[19:16] >= 4'd5) w_adj[19:16] = r_scratch[19:16] + 4'd3;
        w_shifted = w_adj << 1;
    end

    // Converter state and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_bs        <= BS_IDLE;
            r_scratch   <= '0;
            r_shift_cnt <= '0;
            r_deg_hold  <= '0;
            r_grados    <= '0;
            r_cent      <= '0;
            r_dec       <= '0;
            r_uni       <= '0;
            r_valid     <= 1'b0;
        end else begin
            r_bs        <= w_bs_nxt;
            r_scratch   <= w_scr_nxt;
            r_shift_cnt <= w_cnt_nxt;
            r_deg_hold  <= w_hold_nxt;
            r_grados    <= w_grados_nxt;
            r_cent      <= w_cent_nxt;
            r_dec       <= w_dec_nxt;
            r_uni       <= w_uni_nxt;
            r_valid     <= w_valid_nxt;
        end
    end

    // Load on accept (only when idle), 8 shifts, then publish all outputs.
    always_comb begin
        w_bs_nxt     = r_bs;
        w_scr_nxt    = r_scratch;
        w_cnt_nxt    = r_shift_cnt;
        w_hold_nxt   = r_deg_hold;
        w_grados_nxt = r_grados;
        w_cent_nxt   = r_cent;
        w_dec_nxt    = r_dec;
        w_uni_nxt    = r_uni;
        w_valid_nxt  = 1'b0;
        case (r_bs)
            BS_IDLE: begin
                if (r_accept) begin
                    w_scr_nxt  = {12'd0, r_accept_deg};
                    w_hold_nxt = r_accept_deg;
                    w_cnt_nxt  = '0;
                    w_bs_nxt   = BS_SHIFT;
                end
            end
            BS_SHIFT: begin
                w_scr_nxt = w_shifted;
                w_cnt_nxt = r_shift_cnt + 3'd1;
                if (r_shift_cnt == 3'd7)
                    w_bs_nxt = BS_DONE;
            end
            BS_DONE: begin
                w_grados_nxt = r_deg_hold;
                w_cent_nxt   = r_scratch[17:16];
                w_dec_nxt    = r_scratch[15:12];
                w_uni_nxt    = r_scratch[11:8];
                w_valid_nxt  = 1'b1;
                w_bs_nxt     = BS_IDLE;
            end
            default: w_bs_nxt = BS_IDLE;
        endcase
    end

    // ---------------- loss detection -----------------------------------------
    logic [31:0] r_period, w_period_nxt;
    logic        r_lost;

    always_comb begin
        w_period_nxt = r_period;
        if (w_rise)
            w_period_nxt = '0;
        else if (r_period != TIMEOUT)
            w_period_nxt = r_period + 32'd1;
    end

    // Lost flag: set when the period counter saturates, cleared together with
    // the valid pulse; the clear takes priority.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period <= TIMEOUT;
            r_lost   <= 1'b1;
        end else begin
            r_period <= w_period_nxt;
            if (w_valid_nxt)
                r_lost <= 1'b0;
            else if (w_period_nxt == TIMEOUT)
                r_lost <= 1'b1;
        end
    end

    // ---------------- outputs ------------------------------------------------
    assign bus.grados      = r_grados;
    assign bus.valid       = r_valid;
    assign bus.signal_lost = r_lost;
    assign bus.centenas    = r_cent;
    assign bus.decenas     = r_dec;
    assign bus.unidades    = r_uni;

    segmentos_7 u_seg_uni (.i_bcd(r_uni),           .o_seg(bus.wire_unidades));
    segmentos_7 u_seg_dec (.i_bcd(r_dec),           .o_seg(bus.wire_decenas));
    segmentos_7 u_seg_cen (.i_bcd({2'b00, r_cent}), .o_seg(bus.wire_centenas));
endmodule
`default_nettype wire

// File: tb/tb_pwm_grados_decoder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pwm_grados_decoder
//  Description : Directed self-checking bench for pwm_grados_decoder using
//                scaled-down timing parameters.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_pwm_grados_decoder;
    localparam int c_MIN     = 500;
    localparam int c_STEP    = 3;
    localparam int c_MAX     = 180;
    localparam int c_GLITCH  = 100;
    localparam int c_TIMEOUT = 3000;

    localparam logic [6:0] c_SEG0 = 7'b1000000;
    localparam logic [6:0] c_SEG1 = 7'b1111001;
    localparam logic [6:0] c_SEG4 = 7'b0011001;
    localparam logic [6:0] c_SEG8 = 7'b0000000;
    localparam logic [6:0] c_SEG9 = 7'b0010000;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   valid_cnt = 0;
    int   last_valid_cyc = -1;
    int   n_vec = 0;
    int   n_err = 0;

    pwm_grados_decoder_if bus ();

    pwm_grados_decoder #(
        .MIN_PULSE (c_MIN),
        .STEP      (c_STEP),
        .MAX_DEG   (c_MAX),
        .GLITCH    (c_GLITCH),
        .TIMEOUT   (c_TIMEOUT)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Count valid pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.valid === 1'b1) begin
            valid_cnt      <= valid_cnt + 1;
            last_valid_cyc <= cyc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic decode(input string name, input int w, input int exp_deg,
                          input int ec, input int ed, input int eu);
        int vc0;
        int fall;
        vc0 = valid_cnt;
        bus.pwm_in = 1'b1;
        tick(w);
        bus.pwm_in = 1'b0;
        fall = cyc + 1;
        tick(30);
        n_vec++; if (valid_cnt - vc0 !== 1) begin n_err++; $display("FAIL %s valid_count: got %0d expected 1", name, valid_cnt - vc0); end
        n_vec++; if (last_valid_cyc !== fall + 12) begin n_err++; $display("FAIL %s latency: got %0d expected %0d", name, last_valid_cyc - fall, 12); end
        n_vec++; if (bus.grados !== 8'(exp_deg)) begin n_err++; $display("FAIL %s grados: got %0d expected %0d", name, bus.grados, exp_deg); end
        n_vec++; if ({bus.centenas, bus.decenas, bus.unidades} !== {2'(ec), 4'(ed), 4'(eu)}) begin
            n_err++; $display("FAIL %s digits: got %0d/%0d/%0d expected %0d/%0d/%0d", name, bus.centenas, bus.decenas, bus.unidades, ec, ed, eu);
        end
        n_vec++; if (bus.signal_lost !== 1'b0) begin n_err++; $display("FAIL %s signal_lost: got %0b expected 0", name, bus.signal_lost); end
        tick(100);
    endtask

    task automatic test_reset();
        bus.pwm_in = 1'b1;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(2000);
        bus.pwm_in = 1'b0;
        tick(100);
        n_vec++; if (bus.grados !== 8'd0) begin n_err++; $display("FAIL reset grados: got %0d expected 0", bus.grados); end
        n_vec++; if (bus.signal_lost !== 1'b1) begin n_err++; $display("FAIL reset signal_lost: got %0b expected 1", bus.signal_lost); end
        n_vec++; if ({bus.centenas, bus.decenas, bus.unidades} !== 10'd0) begin n_err++; $display("FAIL reset digits: got %0d/%0d/%0d expected 0/0/0", bus.centenas, bus.decenas, bus.unidades); end
        n_vec++; if (bus.wire_unidades !== c_SEG0 || bus.wire_decenas !== c_SEG0 || bus.wire_centenas !== c_SEG0) begin
            n_err++; $display("FAIL reset seg: got %b/%b/%b expected %b", bus.wire_centenas, bus.wire_decenas, bus.wire_unidades, c_SEG0);
        end
        n_vec++; if (valid_cnt !== 0) begin n_err++; $display("FAIL reset valid: got %0d expected 0", valid_cnt); end
    endtask

    task automatic test_nominal();
        decode("nominal90", 771, 90, 0, 9, 0);
        n_vec++; if (bus.wire_decenas !== c_SEG9 || bus.wire_unidades !== c_SEG0) begin
            n_err++; $display("FAIL nominal seg: got %b/%b expected %b/%b", bus.wire_decenas, bus.wire_unidades, c_SEG9, c_SEG0);
        end
    endtask

    task automatic test_limits();
        decode("w_min_m1", c_MIN - 1, 0, 0, 0, 0);
        decode("w_step_m1", c_MIN + c_STEP - 1, 0, 0, 0, 0);
        decode("w_step", c_MIN + c_STEP, 1, 0, 0, 1);
        decode("w_full", c_MIN + c_MAX * c_STEP, 180, 1, 8, 0);
        n_vec++; if (bus.wire_centenas !== c_SEG1 || bus.wire_decenas !== c_SEG8) begin
            n_err++; $display("FAIL full seg: got %b/%b expected %b/%b", bus.wire_centenas, bus.wire_decenas, c_SEG1, c_SEG8);
        end
        decode("w_sat", 1200, 180, 1, 8, 0);
        decode("w_glitch_edge", c_GLITCH, 0, 0, 0, 0);
        decode("w_40", 621, 40, 0, 4, 0);
        n_vec++; if (bus.wire_decenas !== c_SEG4) begin n_err++; $display("FAIL deg40 seg: got %b expected %b", bus.wire_decenas, c_SEG4); end
    endtask

    task automatic test_glitch();
        int vc0;
        decode("pre_glitch", 771, 90, 0, 9, 0);
        vc0 = valid_cnt;
        bus.pwm_in = 1'b1; tick(50);  bus.pwm_in = 1'b0; tick(60);
        bus.pwm_in = 1'b1; tick(c_GLITCH - 1); bus.pwm_in = 1'b0; tick(60);
        n_vec++; if (valid_cnt !== vc0) begin n_err++; $display("FAIL glitch valid: got %0d expected %0d", valid_cnt, vc0); end
        n_vec++; if (bus.grados !== 8'd90) begin n_err++; $display("FAIL glitch grados: got %0d expected 90", bus.grados); end
    endtask

    task automatic test_loss();
        int r;
        int vc0;
        vc0 = valid_cnt;
        bus.pwm_in = 1'b1;
        r = cyc;
        tick(771);
        bus.pwm_in = 1'b0;
        tick(r + c_TIMEOUT + 2 - cyc);
        n_vec++; if (valid_cnt - vc0 !== 1) begin n_err++; $display("FAIL loss pulse valid: got %0d expected 1", valid_cnt - vc0); end
        n_vec++; if (bus.signal_lost !== 1'b0) begin n_err++; $display("FAIL loss early: got %0b expected 0", bus.signal_lost); end
        tick(1);
        n_vec++; if (bus.signal_lost !== 1'b1) begin n_err++; $display("FAIL loss set: got %0b expected 1", bus.signal_lost); end
        n_vec++; if (bus.grados !== 8'd90) begin n_err++; $display("FAIL loss hold: got %0d expected 90", bus.grados); end
        vc0 = valid_cnt;
        bus.pwm_in = 1'b1;
        tick(3500);
        bus.pwm_in = 1'b0;
        tick(50);
        n_vec++; if (valid_cnt !== vc0) begin n_err++; $display("FAIL stuck valid: got %0d expected %0d", valid_cnt, vc0); end
        n_vec++; if (bus.signal_lost !== 1'b1) begin n_err++; $display("FAIL stuck lost: got %0b expected 1", bus.signal_lost); end
        decode("after_loss", 621, 40, 0, 4, 0);
    endtask

    task automatic test_mid_reset();
        int vc0;
        bus.pwm_in = 1'b1;
        tick(300);
        rst = 1'b1;
        tick(3);
        n_vec++; if (bus.grados !== 8'd0 || bus.signal_lost !== 1'b1 || bus.valid !== 1'b0) begin
            n_err++; $display("FAIL midrst state: got grados=%0d lost=%0b valid=%0b expected 0/1/0", bus.grados, bus.signal_lost, bus.valid);
        end
        n_vec++; if ({bus.centenas, bus.decenas, bus.unidades} !== 10'd0) begin n_err++; $display("FAIL midrst digits: got %0d/%0d/%0d expected 0/0/0", bus.centenas, bus.decenas, bus.unidades); end
        rst = 1'b0;
        vc0 = valid_cnt;
        tick(468);
        bus.pwm_in = 1'b0;
        tick(40);
        n_vec++; if (valid_cnt !== vc0) begin n_err++; $display("FAIL midrst valid: got %0d expected %0d", valid_cnt, vc0); end
        decode("after_midrst", 621, 40, 0, 4, 0);
    endtask

    initial begin
        bus.pwm_in = 1'b1;
        test_reset();
        test_nominal();
        test_limits();
        test_glitch();
        test_loss();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
`default_nettype wire

// File: doc/pwm_grados_decoder.md
# pwm_grados_decoder

Receive-side counterpart of the servo PWM generator. Samples an external servo PWM signal, measures the high time of each pulse, and converts it back to an angle in degrees using the same pulse-width law the generator drives. The angle is presented in binary, as three BCD digits, and on three seven-segment displays through existing `segmentos_7` instances. Used for loopback verification of the generator and for reading third-party servo controllers.

## Interface

Parameters:
- `MIN_PULSE`, default 50000: high-time cycles that map to 0°; 1 ms at 50 MHz.
- `STEP`, default 277: clock cycles per degree above `MIN_PULSE`.
- `MAX_DEG`, default 180: saturation angle.
- `GLITCH`, default 1000: pulses shorter than this many cycles are discarded.
- `TIMEOUT`, default 2000000: cycles without a rising edge before loss of signal is flagged; 40 ms.

Ports:
- `clk`, in, 1: single clock.
- `rst`, in, 1: synchronous, active-high reset.
- `pwm_in`, in, 1: asynchronous PWM input.
- `grados`, out, 8: last decoded angle, 0..`MAX_DEG`.
- `valid`, out, 1: one-cycle pulse when `grados` and the digits update.
- `signal_lost`, out, 1: no valid PWM activity.
- `unidades`, `decenas`, out, 4 each: BCD digits of `grados`.
- `centenas`, out, 2: BCD hundreds digit, range 0..1.
- `wire_unidades`, `wire_decenas`, `wire_centenas`, out, 7 each: `segmentos_7` outputs for the digits.

## Operation

- **Input synchronizer.** Two-flop synchronizer on `pwm_in`, plus one delay flop for edge detection.
  - All three flops reset to 1. A pulse already high at reset release therefore never produces a rising edge.
- **Measurement FSM**, states WAIT_RISE and HIGH:
  - WAIT_RISE: a rising edge clears `hi_cnt`, `step_cnt`, `deg_acc`, and `period_cnt`, then moves to HIGH. Falling edges are ignored in this state.
  - HIGH: `hi_cnt` increments each cycle the synchronized input is high.
    - Once `hi_cnt` ≥ `MIN_PULSE`, `step_cnt` counts 0..`STEP`-1 and wraps.
    - Each wrap increments `deg_acc`, which saturates at `MAX_DEG`.
  - Falling edge in HIGH, with W = number of high samples:
    - W < `GLITCH`: discard and return to WAIT_RISE; outputs unchanged.
    - Otherwise: accept `deg_acc` and return to WAIT_RISE.
    - Result: deg = 0 if W < `MIN_PULSE`, else min(`MAX_DEG`, floor((W − `MIN_PULSE`)/`STEP`)).
  - `hi_cnt` reaches `TIMEOUT` in HIGH (input stuck high): return to WAIT_RISE, no accept.
- **Loss detection.**
  - `period_cnt` is 32-bit. It increments every cycle, clears on each rising edge, and saturates at `TIMEOUT`.
  - `signal_lost` sets when `period_cnt` = `TIMEOUT`. It clears on the cycle `valid` pulses.
  - `grados` and the digits hold their last values while lost.
- **BCD converter FSM**, states IDLE, SHIFT, DONE:
  - An accept loads deg into an iterative double-dabble converter: 8 SHIFT cycles, then DONE.
  - In DONE, `grados`, `centenas`, `decenas`, and `unidades` update together and `valid` pulses.
  - An accept arriving while not in IDLE is dropped. This is unreachable with legal parameters.
- **Displays.** The three `segmentos_7` instances are purely combinational from the registered digits.

## Timing

- **Reset values:**
  - `grados` = 0, `valid` = 0, `signal_lost` = 1.
  - All digits 0; seven-segment outputs show the `segmentos_7` code for 0.
  - Both FSMs idle.
- **Latency:** `valid` asserts exactly 12 clk cycles after the first rising clk edge that samples `pwm_in` low following an accepted pulse. The 12 cycles break down as 2 synchronizer + 1 edge detect + 1 accept + 8 shift.
- **Valid width:** `valid` is high for exactly 1 cycle per accepted pulse.
- **Register timing:** all outputs are registered except the seven-segment wires.
- **Reset mid-pulse:** the partial pulse is discarded. The next complete pulse (new rising edge) decodes normally.
- **Boundary values:**
  - W = `MIN_PULSE` − 1 → 0.
  - W = `MIN_PULSE` + `STEP` − 1 → 0.
  - W = `MIN_PULSE` + `STEP` → 1.
  - W ≥ `MIN_PULSE` + `MAX_DEG`·`STEP` → `MAX_DEG`.
- **Simultaneous events:** if `signal_lost` set and a `valid` pulse occur in the same cycle, clear wins.

## Test plan

1. Reset: hold `rst` = 1 for 3 cycles with `pwm_in` = 1, then release and keep `pwm_in` high for 10000 cycles before dropping it.
   - Required: `grados` = 0, `signal_lost` = 1, digits 0/0/0, and no `valid`.
2. Nominal: 74930-cycle pulse in a 1000000-cycle period.
   - Required: `valid` once, 12 cycles after the fall; `grados` = 90; digits 0/9/0; `signal_lost` = 0.
3. Limits:
   - W = 49999 → `grados` = 0.
   - W = 50277 → 1.
   - W = 120000 → 180, digits 1/8/0.
4. Glitch: 500-cycle pulse after a decoded 90°.
   - Required: no `valid`; `grados` stays 90.
5. Loss: stop pulses with `pwm_in` low.
   - Required: `signal_lost` = 1 exactly `TIMEOUT` cycles after the last rising edge; `grados` held.
   - Then apply a stuck-high input: no `valid`. A following legal pulse clears `signal_lost`.
6. Mid-pulse reset: assert `rst` 30000 cycles into a 74930-cycle pulse.
   - Required: outputs at reset values and no `valid` for that pulse. The next 61080-cycle pulse yields `grados` = 40.
